instr_prefetch_queue: RTL and testbench



---
 rtl/instr_prefetch_queue.sv | 82 ++++++++
 tb/tb_instr_prefetch_queue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, buffers {pc, instr} pairs read from a
// combinational ROM and presents the oldest to decode; a redirect flushes and reloads the PC.
module instr_prefetch_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned PC_W    = 10,
    parameter int unsigned INSTR_W = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       halted,
    input  logic                       redirect,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic [PC_W-1:0]            rom_addr,
    input  logic [INSTR_W-1:0]         rom_data,
    output logic                       out_valid,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [PC_W-1:0]            out_pc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PC_W-1:0]  fetch_pc;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_c;
    logic             pop_c;
    entry_t           head_c;

    // A full queue may still accept a fetch when the head leaves in the same cycle.
    always_comb begin
        pop_c  = out_valid & out_ready;
        push_c = !redirect && !halted && ((count < CNT_W'(DEPTH)) || pop_c);
    end

    // Entry storage carries no reset; unread slots are masked by out_valid.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= '{pc: fetch_pc, instr: rom_data};
        end
    end

    // Redirect flush wins over any push/pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push_c) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                fetch_pc <= fetch_pc + PC_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    assign head_c    = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign out_instr = out_valid ? head_c.instr : '0;
    assign out_pc    = out_valid ? head_c.pc : '0;
    assign rom_addr  = fetch_pc;
    assign occupancy = count;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: expected PCs are queued as stimulus is applied
// and checked in order whenever decode accepts the head entry.
module tb_instr_prefetch_queue;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned PC_W    = 10;
    localparam int unsigned INSTR_W = 10;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               halted = 1'b0;
    logic               redirect = 1'b0;
    logic [PC_W-1:0]    redirect_pc = '0;
    logic [PC_W-1:0]    rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic               out_ready = 1'b0;
    logic [CNT_W-1:0]   occupancy;

    int vectors = 0;
    int miscompares = 0;
    logic [PC_W-1:0] sb[$];

    instr_prefetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk(clk), .rst_n(rst_n), .halted(halted), .redirect(redirect),
        .redirect_pc(redirect_pc), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_ready(out_ready), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] rom_fn(input logic [PC_W-1:0] a);
        logic [31:0] t;
        t = 32'(a) + 32'h100;
        return INSTR_W'(t);
    endfunction

    assign rom_data = rom_fn(rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare an accepted head against the scoreboard, then advance one clock.
    task automatic cyc();
        logic [PC_W-1:0] exp_pc;
        if (out_valid && out_ready) begin
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("FAIL sb_underflow: observed out_pc 0x%0h expected no transfer", out_pc);
            end
            if (sb.size() != 0) begin
                exp_pc = sb.pop_front();
                chk("head_pc", 32'(out_pc), 32'(exp_pc));
                chk("head_instr", 32'(out_instr), 32'(rom_fn(exp_pc)));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready_val);
        rst_n = 1'b0;
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_pc", 32'(out_pc), 32'd0);
        chk("rst_instr", 32'(out_instr), 32'd0);
        sb.delete();
        @(negedge clk);
        out_ready = ready_val;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        #1;
        // Streaming: one instruction per cycle, occupancy 1
        do_reset(1'b1);
        for (int i = 0; i < 6; i++) sb.push_back(PC_W'(i));
        for (int i = 0; i < 6; i++) begin
            chk("stream_occ", 32'(occupancy), 32'd1);
            cyc();
        end

        // Stall fills to DEPTH, then drain while full keeps refilling
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) begin
            chk("fill_occ", 32'(occupancy), (i < 4) ? 32'(i + 1) : 32'd4);
            if (i < 5) cyc();
        end
        chk("fill_rom_addr", 32'(rom_addr), 32'd4);
        chk("fill_head_pc", 32'(out_pc), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) sb.push_back(PC_W'(i));
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("full_pp_occ", 32'(occupancy), 32'd4);
        end
        chk("full_pp_rom_addr", 32'(rom_addr), 32'd10);

        // Redirect from full queue
        redirect = 1'b1;
        redirect_pc = 10'h3F0;
        sb.push_back(10'd6);
        cyc();
        redirect = 1'b0;
        chk("redir_valid", 32'(out_valid), 32'd0);
        chk("redir_occ", 32'(occupancy), 32'd0);
        chk("redir_pc0", 32'(out_pc), 32'd0);
        chk("redir_instr0", 32'(out_instr), 32'd0);
        chk("redir_rom_addr", 32'(rom_addr), 32'h3F0);
        sb.push_back(10'h3F0);
        sb.push_back(10'h3F1);
        cyc();
        chk("redir_valid_after", 32'(out_valid), 32'd1);
        cyc();

        // Redirect near the top of the address space: PC wraps
        redirect = 1'b1;
        redirect_pc = 10'h3FE;
        cyc();
        redirect = 1'b0;
        chk("wrap_bubble", 32'(out_valid), 32'd0);
        sb.push_back(10'h3FE);
        sb.push_back(10'h3FF);
        sb.push_back(10'h000);
        sb.push_back(10'h001);
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("wrap_occ", 32'(occupancy), 32'd1);
            cyc();
        end

        // Halt at occupancy 3: queue drains, PC frozen, then resumes
        out_ready = 1'b0;
        cyc();
        cyc();
        chk("pre_halt_occ", 32'(occupancy), 32'd3);
        halted = 1'b1;
        out_ready = 1'b1;
        sb.push_back(10'd2);
        sb.push_back(10'd3);
        sb.push_back(10'd4);
        cyc();
        chk("halt_occ2", 32'(occupancy), 32'd2);
        chk("halt_rom_addr", 32'(rom_addr), 32'd5);
        cyc();
        chk("halt_occ1", 32'(occupancy), 32'd1);
        cyc();
        chk("halt_valid", 32'(out_valid), 32'd0);
        chk("halt_occ0", 32'(occupancy), 32'd0);
        cyc();
        chk("halt_hold_rom_addr", 32'(rom_addr), 32'd5);
        halted = 1'b0;
        sb.push_back(10'd5);
        sb.push_back(10'd6);
        cyc();
        cyc();
        cyc();

        // Asynchronous reset between edges at occupancy 3
        out_ready = 1'b0;
        cyc();
        cyc();
        chk("pre_arst_occ", 32'(occupancy), 32'd3);
        chk("pre_arst_rom_addr", 32'(rom_addr), 32'd10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_occ", 32'(occupancy), 32'd0);
        chk("arst_rom_addr", 32'(rom_addr), 32'd0);
        chk("arst_pc", 32'(out_pc), 32'd0);
        sb.delete();
        out_ready = 1'b1;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_restart_valid", 32'(out_valid), 32'd1);
        sb.push_back(10'd0);
        sb.push_back(10'd1);
        cyc();
        cyc();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
